// File: rtl/video_layer_mixer_if.sv
// Pixel stream bundle for the layer mixer: per-layer input pixels with shared
// timing, and the composited output stream with its delayed timing.
interface video_layer_mixer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int DATA_W     = 16
);
  logic                         i_vs;
  logic                         i_hs;
  logic                         i_de;
  logic [NUM_LAYERS*DATA_W-1:0] i_layer_data;
  logic [NUM_LAYERS-1:0]        i_layer_valid;
  logic                         o_vs;
  logic                         o_hs;
  logic                         o_de;
  logic [DATA_W-1:0]            o_rgb;

  modport master (
    output i_vs, i_hs, i_de, i_layer_data, i_layer_valid,
    input  o_vs, o_hs, o_de, o_rgb
  );

  modport slave (
    input  i_vs, i_hs, i_de, i_layer_data, i_layer_valid,
    output o_vs, o_hs, o_de, o_rgb
  );
endinterface

// File: rtl/video_layer_mixer.sv
// RGB565 layer compositor: opaque / colour-key / 50% blend per layer, with
// configuration shadowed at each frame start and a fixed 2-cycle pipeline.
module video_layer_mixer #(
  parameter int   NUM_LAYERS = 3,
  parameter int   DATA_W     = 16,
  parameter logic VS_POL     = 1'b1,
  parameter int   CNT_W      = 16
) (
  input  logic                    clk_ctrl,
  input  logic                    reset_n,
  input  logic [NUM_LAYERS-1:0]   cfg_layer_en,
  input  logic [2*NUM_LAYERS-1:0] cfg_mode,
  input  logic [DATA_W-1:0]       cfg_key,
  input  logic [DATA_W-1:0]       cfg_bg_color,
  video_layer_mixer_if.slave      vid,
  output logic [CNT_W-1:0]        o_frame_cnt,
  output logic                    o_cfg_applied
);

  localparam logic [1:0] MODE_KEY   = 2'b01;
  localparam logic [1:0] MODE_BLEND = 2'b10;

  // Halve each colour field separately so no carry crosses field boundaries.
  function automatic logic [DATA_W-1:0] blend50(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r        = '0;
    r[15:11] = {1'b0, a[15:12]} + {1'b0, b[15:12]};
    r[10:5]  = {1'b0, a[10:6]}  + {1'b0, b[10:6]};
    r[4:0]   = {1'b0, a[4:1]}   + {1'b0, b[4:1]};
    return r;
  endfunction

  logic                         vs_prev_q,      vs_prev_d;
  logic [NUM_LAYERS-1:0]        shadow_en_q,    shadow_en_d;
  logic [2*NUM_LAYERS-1:0]      shadow_mode_q,  shadow_mode_d;
  logic [DATA_W-1:0]            shadow_key_q,   shadow_key_d;
  logic [DATA_W-1:0]            shadow_bg_q,    shadow_bg_d;
  logic [CNT_W-1:0]             frame_cnt_q,    frame_cnt_d;
  logic                         cfg_applied_q,  cfg_applied_d;
  logic [NUM_LAYERS*DATA_W-1:0] s1_data_q,      s1_data_d;
  logic [NUM_LAYERS-1:0]        s1_contrib_q,   s1_contrib_d;
  logic [2*NUM_LAYERS-1:0]      s1_mode_q,      s1_mode_d;
  logic [DATA_W-1:0]            s1_bg_q,        s1_bg_d;
  logic                         s1_de_q,        s1_de_d;
  logic                         s1_hs_q,        s1_hs_d;
  logic                         s1_vs_q,        s1_vs_d;
  logic [DATA_W-1:0]            out_rgb_q,      out_rgb_d;
  logic                         out_de_q,       out_de_d;
  logic                         out_hs_q,       out_hs_d;
  logic                         out_vs_q,       out_vs_d;
  logic                         frame_start_s;
  logic [DATA_W-1:0]            acc_s;

  // Frame-start detection, shadow loading and the frame counter.
  always_comb begin
    frame_start_s = (vid.i_vs == VS_POL) && (vs_prev_q != VS_POL);
    vs_prev_d     = vid.i_vs;
    cfg_applied_d = frame_start_s;
    if (frame_start_s) begin
      shadow_en_d   = cfg_layer_en;
      shadow_mode_d = cfg_mode;
      shadow_key_d  = cfg_key;
      shadow_bg_d   = cfg_bg_color;
      frame_cnt_d   = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      shadow_en_d   = shadow_en_q;
      shadow_mode_d = shadow_mode_q;
      shadow_key_d  = shadow_key_q;
      shadow_bg_d   = shadow_bg_q;
      frame_cnt_d   = frame_cnt_q;
    end
  end

  // Stage 1: capture pixels with the shadow values current on entry.
  always_comb begin
    s1_data_d    = vid.i_layer_data;
    s1_mode_d    = shadow_mode_q;
    s1_bg_d      = shadow_bg_q;
    s1_de_d      = vid.i_de;
    s1_hs_d      = vid.i_hs;
    s1_vs_d      = vid.i_vs;
    s1_contrib_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      s1_contrib_d[k] = shadow_en_q[k] & vid.i_layer_valid[k] &
                        ~((shadow_mode_q[2*k +: 2] == MODE_KEY) &&
                          (vid.i_layer_data[k*DATA_W +: DATA_W] == shadow_key_q));
    end
  end

  // Stage 2: fold layers bottom to top over the background colour.
  always_comb begin
    acc_s = s1_bg_q;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (s1_contrib_q[k]) begin
        case (s1_mode_q[2*k +: 2])
          MODE_BLEND: acc_s = blend50(acc_s, s1_data_q[k*DATA_W +: DATA_W]);
          default:    acc_s = s1_data_q[k*DATA_W +: DATA_W];
        endcase
      end else begin
        acc_s = acc_s;
      end
    end
    if (s1_de_q) begin
      out_rgb_d = acc_s;
    end else begin
      out_rgb_d = '0;
    end
    out_de_d = s1_de_q;
    out_hs_d = s1_hs_q;
    out_vs_d = s1_vs_q;
  end

  // State registers; vs_prev resets to the active level so a vsync held
  // active across reset release is not mistaken for a frame start.
  always_ff @(posedge clk_ctrl) begin
    if (!reset_n) begin
      vs_prev_q     <= VS_POL;
      shadow_en_q   <= '0;
      shadow_mode_q <= '0;
      shadow_key_q  <= '0;
      shadow_bg_q   <= '0;
      frame_cnt_q   <= '0;
      cfg_applied_q <= 1'b0;
      s1_data_q     <= '0;
      s1_contrib_q  <= '0;
      s1_mode_q     <= '0;
      s1_bg_q       <= '0;
      s1_de_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= ~VS_POL;
      out_rgb_q     <= '0;
      out_de_q      <= 1'b0;
      out_hs_q      <= 1'b0;
      out_vs_q      <= ~VS_POL;
    end else begin
      vs_prev_q     <= vs_prev_d;
      shadow_en_q   <= shadow_en_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_key_q  <= shadow_key_d;
      shadow_bg_q   <= shadow_bg_d;
      frame_cnt_q   <= frame_cnt_d;
      cfg_applied_q <= cfg_applied_d;
      s1_data_q     <= s1_data_d;
      s1_contrib_q  <= s1_contrib_d;
      s1_mode_q     <= s1_mode_d;
      s1_bg_q       <= s1_bg_d;
      s1_de_q       <= s1_de_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      out_rgb_q     <= out_rgb_d;
      out_de_q      <= out_de_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
    end
  end

  assign vid.o_rgb     = out_rgb_q;
  assign vid.o_de      = out_de_q;
  assign vid.o_hs      = out_hs_q;
  assign vid.o_vs      = out_vs_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_cfg_applied = cfg_applied_q;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer: opaque, colour-key, blend, shadowed
// config, reset behaviour, 2-cycle latency and frame counter wrap.
module tb_video_layer_mixer;
  localparam int NL = 3;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk_ctrl = 1'b0;
  logic          reset_n;
  logic [NL-1:0] cfg_layer_en;
  logic [2*NL-1:0] cfg_mode;
  logic [DW-1:0] cfg_key;
  logic [DW-1:0] cfg_bg_color;
  logic [CW-1:0] frame_cnt;
  logic          cfg_applied;
  logic [CW-1:0] exp_cnt;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            applied_seen = 0;

  video_layer_mixer_if #(.NUM_LAYERS(NL), .DATA_W(DW)) vif ();

  video_layer_mixer #(
    .NUM_LAYERS(NL), .DATA_W(DW), .VS_POL(1'b1), .CNT_W(CW)
  ) dut (
    .clk_ctrl      (clk_ctrl),
    .reset_n       (reset_n),
    .cfg_layer_en  (cfg_layer_en),
    .cfg_mode      (cfg_mode),
    .cfg_key       (cfg_key),
    .cfg_bg_color  (cfg_bg_color),
    .vid           (vif),
    .o_frame_cnt   (frame_cnt),
    .o_cfg_applied (cfg_applied)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  always @(negedge clk_ctrl) begin
    if (cfg_applied) applied_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_ctrl);
      #1;
    end
  endtask

  task automatic set_layers(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [2:0] v);
    vif.i_layer_data  = {d2, d1, d0};
    vif.i_layer_valid = v;
  endtask

  // vsync pulse with de low; checks the applied pulse and the counter.
  task automatic frame_start();
    vif.i_vs = 1'b1;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check_eq("applied_hi", 32'(cfg_applied), 32'd1);
    check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    vif.i_vs = 1'b0;
    tick();
    check_eq("applied_lo", 32'(cfg_applied), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_layer_en = 3'b000; cfg_mode = 6'b000000;
    cfg_key = 16'h0000; cfg_bg_color = 16'h0000;
    vif.i_vs = 1'b0; vif.i_hs = 1'b0; vif.i_de = 1'b0;
    set_layers(16'h0000, 16'h0000, 16'h0000, 3'b000);
    exp_cnt = 4'd0;
    tick(3);
    check_eq("rst_de", 32'(vif.o_de), 32'd0);
    check_eq("rst_rgb", 32'(vif.o_rgb), 32'd0);
    check_eq("rst_vs", 32'(vif.o_vs), 32'd0);
    check_eq("rst_hs", 32'(vif.o_hs), 32'd0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_applied", 32'(cfg_applied), 32'd0);

    // Test 1: L0 opaque red
    reset_n = 1'b1;
    cfg_layer_en = 3'b001; cfg_mode = 6'b000000;
    set_layers(16'hF800, 16'h0000, 16'h0000, 3'b001);
    tick();
    frame_start();
    vif.i_de = 1'b1;
    tick();
    check_eq("t1_de_lat1", 32'(vif.o_de), 32'd0);
    tick();
    check_eq("t1_de_lat2", 32'(vif.o_de), 32'd1);
    check_eq("t1_rgb", 32'(vif.o_rgb), 32'h0000F800);
    check_eq("t1_applied_once", 32'(applied_seen), 32'd1);
    vif.i_de = 1'b0;
    tick(2);

    // Test 2: colour key on L1 over red L0, alternating every pixel
    cfg_layer_en = 3'b011; cfg_mode = 6'b000100; cfg_key = 16'h0000;
    frame_start();
    vif.i_de = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_layers(16'hF800, (i % 2 == 0) ? 16'h0000 : 16'h07E0, 16'h0000, 3'b011);
      tick();
      if (i > 0)
        check_eq("t2_key", 32'(vif.o_rgb), ((i - 1) % 2 == 0) ? 32'h0000F800 : 32'h000007E0);
    end
    tick();
    check_eq("t2_key_last", 32'(vif.o_rgb), 32'h000007E0);
    vif.i_de = 1'b0;
    tick(2);

    // Test 3: L2 blend over black L0 whose data matches key in opaque mode
    cfg_layer_en = 3'b101; cfg_mode = 6'b100000;
    cfg_key = 16'h0000; cfg_bg_color = 16'h001F;
    set_layers(16'h0000, 16'h1234, 16'hFFFF, 3'b111);
    frame_start();
    vif.i_de = 1'b1;
    tick(2);
    check_eq("t3_blend", 32'(vif.o_rgb), 32'h00007BEF);
    vif.i_de = 1'b0;
    tick(2);

    // Test 3b: blend on layer 0 mixes with background
    cfg_layer_en = 3'b001; cfg_mode = 6'b000010;
    set_layers(16'hFFFF, 16'h0000, 16'h0000, 3'b001);
    frame_start();
    vif.i_de = 1'b1;
    tick(2);
    check_eq("t3_blend_bg", 32'(vif.o_rgb), 32'h00007BFE);
    vif.i_de = 1'b0;
    tick(2);

    // Test 4: background change is held off until the next frame start
    cfg_layer_en = 3'b000; cfg_mode = 6'b000000; cfg_bg_color = 16'h001F;
    set_layers(16'h0000, 16'h0000, 16'h0000, 3'b000);
    frame_start();
    vif.i_de = 1'b1;
    tick(2);
    check_eq("t4_bg_old", 32'(vif.o_rgb), 32'h0000001F);
    cfg_bg_color = 16'hFFE0;
    tick(2);
    check_eq("t4_bg_held", 32'(vif.o_rgb), 32'h0000001F);
    vif.i_de = 1'b0;
    tick(2);
    check_eq("t4_rgb_blank", 32'(vif.o_rgb), 32'd0);
    vif.i_de = 1'b1;
    tick(2);
    vif.i_vs = 1'b1;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    check_eq("t4_applied_de", 32'(cfg_applied), 32'd1);
    check_eq("t4_rgb_pre", 32'(vif.o_rgb), 32'h0000001F);
    vif.i_vs = 1'b0;
    tick();
    check_eq("t4_rgb_edge_px", 32'(vif.o_rgb), 32'h0000001F);
    tick();
    check_eq("t4_bg_new", 32'(vif.o_rgb), 32'h0000FFE0);

    // Test 5: reset mid-line with vsync held active through release
    reset_n = 1'b0;
    tick();
    check_eq("t5_de", 32'(vif.o_de), 32'd0);
    check_eq("t5_rgb", 32'(vif.o_rgb), 32'd0);
    check_eq("t5_cnt", 32'(frame_cnt), 32'd0);
    vif.i_vs = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick();
    check_eq("t5_de_after", 32'(vif.o_de), 32'd0);
    check_eq("t5_no_applied", 32'(cfg_applied), 32'd0);
    tick();
    check_eq("t5_de_resume", 32'(vif.o_de), 32'd1);
    check_eq("t5_cnt_held", 32'(frame_cnt), 32'd0);
    check_eq("t5_no_applied2", 32'(cfg_applied), 32'd0);
    vif.i_vs = 1'b0; vif.i_de = 1'b0;
    tick();
    exp_cnt = 4'd0;
    frame_start();
    tick(2);

    // Test 6: 16 more frames wrap the 4-bit counter; check sync latency
    for (int f = 0; f < 16; f++) begin
      vif.i_vs = 1'b1; vif.i_hs = 1'b1; vif.i_de = 1'b1;
      tick();
      exp_cnt = exp_cnt + 4'd1;
      check_eq("t6_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check_eq("t6_applied", 32'(cfg_applied), 32'd1);
      check_eq("t6_lat1", 32'({vif.o_vs, vif.o_hs, vif.o_de}), 32'd0);
      vif.i_vs = 1'b0; vif.i_hs = 1'b0; vif.i_de = 1'b0;
      tick();
      check_eq("t6_lat2", 32'({vif.o_vs, vif.o_hs, vif.o_de}), 32'd7);
      tick();
      check_eq("t6_lat3", 32'({vif.o_vs, vif.o_hs, vif.o_de}), 32'd0);
    end
    check_eq("t6_cnt_end", 32'(frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
